// File: rtl/mdio_pkg.sv
// Shared types and frame constants for the Clause 45 MDIO master.
package mdio_pkg;

  typedef enum logic [1:0] {
    ADDR     = 2'b00,
    WRITE    = 2'b01,
    READ_INC = 2'b10,
    READ     = 2'b11
  } mdio_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_FRAME,
    S_DONE
  } mdio_state_e;

  localparam logic [1:0] ST         = 2'b00;
  localparam logic [1:0] TA_WRITE   = 2'b10;
  localparam int         FRAME_BITS = 32;

  // Both read flavours have op[1] set; the master releases MDIO from TA onward.
  function automatic logic is_read_op(input mdio_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// MDC divider: one bit = low phase then high phase of MDC_HALF_PERIOD cycles each.
// Strobes are qualified by i_run and describe the current cycle of the bit.
module mdio_clkgen #(
  parameter int MDC_HALF_PERIOD = 32
) (
  input  logic clk_i,
  input  logic areset_i,
  input  logic i_start,
  input  logic i_run,
  input  logic i_run_next,
  output logic o_mdc,
  output logic o_rise_stb,
  output logic o_fall_stb,
  output logic o_last_stb
);

  localparam int CW = $clog2(2 * MDC_HALF_PERIOD);
  localparam logic [CW-1:0] CNT_HIGH = CW'(MDC_HALF_PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * MDC_HALF_PERIOD - 1);
  localparam logic [CW-1:0] CNT_PEN  = CW'(2 * MDC_HALF_PERIOD - 2);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_mdc;

  assign w_cnt_next = (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);

  // MDC is registered so the PHY never sees a decode glitch on its clock.
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else if (i_start) begin
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else begin
      if (i_run) r_cnt <= w_cnt_next;
      r_mdc <= i_run_next && (w_cnt_next >= CNT_HIGH);
    end
  end

  assign o_mdc      = r_mdc;
  assign o_rise_stb = i_run && (r_cnt == CNT_HIGH);
  assign o_fall_stb = i_run && (r_cnt == CNT_LAST);
  assign o_last_stb = i_run && (r_cnt == CNT_PEN);

endmodule

// File: rtl/mdio_c45_master.sv
// Clause 45 MDIO master: serialises one management frame per accepted command.
// Build macro MDIO_RD_TA_CHECK_EN flags reads whose second TA bit is not pulled low.
module mdio_c45_master #(
  parameter int MDC_HALF_PERIOD = 32,
  parameter int PREAMBLE_LEN    = 32
) (
  input  logic        clk_i,
  input  logic        areset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [4:0]  cmd_prtad_i,
  input  logic [4:0]  cmd_devad_i,
  input  logic [15:0] cmd_data_i,
  input  logic [2:0]  cmd_lane_i,
  output logic        done_o,
  output logic [15:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic [2:0]  mdio_sel_o,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        mdio_i
);
  import mdio_pkg::*;

  mdio_state_e r_state, w_state_next;
  mdio_op_e    r_op;
  logic [31:0] r_frame;
  logic [2:0]  r_sel;
  logic [4:0]  r_bit;
  logic [15:0] r_rx, w_rx_next, r_rsp;
  logic        w_accept, w_run, w_run_next;
  logic        w_rise, w_fall, w_last;
  logic        w_pre_end, w_frame_end, w_rsp_upd, w_drive;

  assign w_accept    = cmd_valid_i && (r_state == S_IDLE);
  assign w_run       = (r_state == S_PRE) || (r_state == S_FRAME);
  assign w_run_next  = (w_state_next == S_PRE) || (w_state_next == S_FRAME);
  assign w_pre_end   = (r_state == S_PRE) && w_fall && (r_bit == 5'(PREAMBLE_LEN - 1));
  // The last bit is cut one cycle short so done_o lands on the bit's final cycle.
  assign w_frame_end = (r_state == S_FRAME) && w_last && (r_bit == 5'(FRAME_BITS - 1));

  mdio_clkgen #(
    .MDC_HALF_PERIOD(MDC_HALF_PERIOD)
  ) u_clkgen (
    .clk_i      (clk_i),
    .areset_i   (areset_i),
    .i_start    (w_accept),
    .i_run      (w_run),
    .i_run_next (w_run_next),
    .o_mdc      (mdc_o),
    .o_rise_stb (w_rise),
    .o_fall_stb (w_fall),
    .o_last_stb (w_last)
  );

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = (PREAMBLE_LEN == 0) ? S_FRAME : S_PRE;
      S_PRE:   if (w_pre_end) w_state_next = S_FRAME;
      S_FRAME: if (w_frame_end) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    mdio_o      = 1'b1;
    mdio_oe_o   = 1'b0;
    w_drive     = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      S_PRE: mdio_oe_o = 1'b1;
      S_FRAME: begin
        w_drive   = !(is_read_op(r_op) && (r_bit >= 5'd14));
        mdio_oe_o = w_drive;
        mdio_o    = w_drive ? r_frame[5'd31 - r_bit] : 1'b1;
      end
      S_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      r_op    <= ADDR;
      r_frame <= '0;
      r_sel   <= '0;
    end else if (w_accept) begin
      r_op    <= mdio_op_e'(cmd_op_i);
      r_frame <= {ST, cmd_op_i, cmd_prtad_i, cmd_devad_i, TA_WRITE, cmd_data_i};
      r_sel   <= cmd_lane_i;
    end
  end

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i)      r_bit <= '0;
    else if (w_accept) r_bit <= '0;
    else if (w_fall)   r_bit <= w_pre_end ? '0 : r_bit + 5'd1;
  end

  // With short half periods the final data sample coincides with w_frame_end.
  assign w_rx_next = ((r_state == S_FRAME) && w_rise && (r_bit >= 5'd16)) ?
                     {r_rx[14:0], mdio_i} : r_rx;

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i)      r_rx <= '0;
    else if (w_accept) r_rx <= '0;
    else               r_rx <= w_rx_next;
  end

`ifdef MDIO_RD_TA_CHECK_EN
  logic r_ta_bad;
  logic r_err;

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      r_ta_bad <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept)
        r_ta_bad <= 1'b0;
      else if ((r_state == S_FRAME) && w_rise && (r_bit == 5'd15))
        r_ta_bad <= mdio_i;
      if (w_frame_end)
        r_err <= is_read_op(r_op) && r_ta_bad;
    end
  end

  assign w_rsp_upd = w_frame_end && is_read_op(r_op) && !r_ta_bad;
  assign rsp_err_o = r_err;
`else
  assign w_rsp_upd = w_frame_end && is_read_op(r_op);
  assign rsp_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i)       r_rsp <= '0;
    else if (w_rsp_upd) r_rsp <= w_rx_next;
  end

  assign rsp_data_o = r_rsp;
  assign mdio_sel_o = r_sel;

endmodule

// File: tb/tb_mdio_c45_master.sv
// Scoreboard bench for mdio_c45_master: stimulus pushes expected frames, a monitor
// captures MDC/MDIO and checks each frame when done_o pulses.
module tb_mdio_c45_master;
  import mdio_pkg::*;

  localparam int H   = 2;
  localparam int PRE = 32;
  localparam int NB  = PRE + 32;
  localparam int LAT = NB * 2 * H;
  localparam logic [63:0] OE_WR = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] OE_RD = 64'hFFFF_FFFF_FFFC_0000;

  logic        clk_i = 1'b0;
  logic        areset_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i = 2'b00;
  logic [4:0]  cmd_prtad_i = '0;
  logic [4:0]  cmd_devad_i = '0;
  logic [15:0] cmd_data_i = '0;
  logic [2:0]  cmd_lane_i = '0;
  logic        done_o;
  logic [15:0] rsp_data_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic [2:0]  mdio_sel_o;
  logic        mdc_o;
  logic        mdio_o;
  logic        mdio_oe_o;
  logic        mdio_i = 1'b1;

  mdio_c45_master #(
    .MDC_HALF_PERIOD(H),
    .PREAMBLE_LEN(PRE)
  ) dut (
    .clk_i(clk_i), .areset_i(areset_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_prtad_i(cmd_prtad_i), .cmd_devad_i(cmd_devad_i),
    .cmd_data_i(cmd_data_i), .cmd_lane_i(cmd_lane_i),
    .done_o(done_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o), .mdio_sel_o(mdio_sel_o),
    .mdc_o(mdc_o), .mdio_o(mdio_o), .mdio_oe_o(mdio_oe_o), .mdio_i(mdio_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] bits;
    logic [63:0] oe;
    logic [15:0] rdata;
    logic        err;
    logic [2:0]  lane;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int rises = 0;
  logic mdc_prev = 1'b0;
  logic post_done = 1'b0;
  logic hs_check = 1'b0;
  logic [63:0] cap_b, cap_oe;
  logic phy_present = 1'b1;
  logic [15:0] phy_word = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(posedge clk_i) cyc++;

  // Monitor + PHY model
  always @(negedge clk_i) begin
    if (areset_i) begin
      rises = 0;
      mdc_prev = 1'b0;
      post_done = 1'b0;
      mdio_i = 1'b1;
    end else begin
      if (post_done) begin
        chk("ready_after_done", cmd_ready_o, 1);
        chk("busy_after_done", busy_o, 0);
        chk("idle_mdc_low", mdc_o, 0);
        post_done = 1'b0;
      end
      if (cmd_valid_i && cmd_ready_o) begin
        acc_cyc = cyc;
        acc_cnt++;
        rises = 0;
        cap_b = '0;
        cap_oe = '0;
        if (hs_check) begin
          chk("b2b_accept_gap", cyc - last_done_cyc, 1);
          hs_check = 1'b0;
        end
      end
      if (!mdc_prev && mdc_o) begin
        cap_b = {cap_b[62:0], mdio_o};
        cap_oe = {cap_oe[62:0], mdio_oe_o};
        rises++;
      end
      if (mdc_prev && !mdc_o) begin
        int f;
        f = rises - PRE;
        if (f == 15) mdio_i = phy_present ? 1'b0 : 1'b1;
        else if (f >= 16 && f <= 31) mdio_i = phy_present ? phy_word[31 - f] : 1'b1;
        else mdio_i = 1'b1;
      end
      if (done_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done_o=1, required no pending frame");
        end else begin
          e_mon = exp_q.pop_front();
          chk("latency", cyc - acc_cyc, LAT);
          chk("bit_count", rises, NB);
          chk("oe_pattern", cap_oe, e_mon.oe);
          chk("mdio_bits", cap_b & e_mon.oe, e_mon.bits & e_mon.oe);
          chk("rsp_data", rsp_data_o, e_mon.rdata);
          chk("rsp_err", rsp_err_o, e_mon.err);
          chk("lane_sel", mdio_sel_o, e_mon.lane);
          chk("done_mdc", mdc_o, 0);
          chk("done_oe", mdio_oe_o, 0);
          chk("done_mdio", mdio_o, 1);
        end
        done_cnt++;
        last_done_cyc = cyc;
        post_done = 1'b1;
      end
      mdc_prev = mdc_o;
    end
  end

  task automatic expect_frame(input logic [31:0] lo, input logic rd, input logic [15:0] rdata,
                              input logic err, input logic [2:0] lane);
    exp_t e;
    e.bits  = {32'hFFFF_FFFF, lo};
    e.oe    = rd ? OE_RD : OE_WR;
    e.rdata = rdata;
    e.err   = err;
    e.lane  = lane;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] op, input logic [4:0] prtad, input logic [4:0] devad,
                       input logic [15:0] data, input logic [2:0] lane);
    cmd_op_i    = op;
    cmd_prtad_i = prtad;
    cmd_devad_i = devad;
    cmd_data_i  = data;
    cmd_lane_i  = lane;
    cmd_valid_i = 1'b1;
  endtask

  task automatic wait_accept();
    int t = 0;
    while (!cmd_ready_o && t < 1000) begin
      @(negedge clk_i);
      t++;
    end
    chk("wait_ready", cmd_ready_o, 1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] prtad, input logic [4:0] devad,
                      input logic [15:0] data, input logic [2:0] lane);
    drive(op, prtad, devad, data, lane);
    wait_accept();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 1000) begin
      @(negedge clk_i);
      t++;
    end
    chk("wait_done", done_cnt, target);
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0;
    repeat (2) @(negedge clk_i);
    chk("rst_mdc", mdc_o, 0);
    chk("rst_mdio", mdio_o, 1);
    chk("rst_oe", mdio_oe_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_rsp", rsp_data_o, 0);
    chk("rst_err", rsp_err_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_sel", mdio_sel_o, 0);
    chk("rst_ready", cmd_ready_o, 1);
    areset_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // address op
    expect_frame(32'h0006_0020, 1'b0, 16'h0000, 1'b0, 3'd5);
    send(ADDR, 5'd0, 5'd1, 16'h0020, 3'd5);
    chk("sel_after_accept", mdio_sel_o, 5);
    chk("busy_in_frame", busy_o, 1);
    wait_done(1);

    // write op
    expect_frame(32'h1006_A5C3, 1'b0, 16'h0000, 1'b0, 3'd2);
    send(WRITE, 5'd0, 5'd1, 16'hA5C3, 3'd2);
    wait_done(2);

    // read op with PHY responding
    phy_present = 1'b1;
    phy_word = 16'h1234;
    expect_frame(32'h3184_0000, 1'b1, 16'h1234, 1'b0, 3'd3);
    send(READ, 5'd3, 5'd1, 16'hDEAD, 3'd3);
    wait_done(3);

    // read with no PHY
    phy_present = 1'b0;
`ifdef MDIO_RD_TA_CHECK_EN
    expect_frame(32'h3004_0000, 1'b1, 16'h1234, 1'b1, 3'd1);
`else
    expect_frame(32'h3004_0000, 1'b1, 16'hFFFF, 1'b0, 3'd1);
`endif
    send(READ, 5'd0, 5'd1, 16'h0000, 3'd1);
    wait_done(4);

    // back-to-back with cmd_valid_i held through the first frame
    phy_present = 1'b1;
    phy_word = 16'hBEEF;
    a0 = acc_cnt;
    expect_frame(32'h210C_0000, 1'b1, 16'hBEEF, 1'b0, 3'd0);
    drive(READ_INC, 5'd2, 5'd3, 16'h0000, 3'd0);
    wait_accept();
    expect_frame(32'h0FFE_0001, 1'b0, 16'hBEEF, 1'b0, 3'd7);
    hs_check = 1'b1;
    drive(ADDR, 5'd31, 5'd31, 16'h0001, 3'd7);
    @(negedge clk_i);
    wait_accept();
    cmd_valid_i = 1'b0;
    wait_done(6);
    chk("accept_count", acc_cnt - a0, 2);
    chk("hs_gap_seen", hs_check, 0);

    // reset during bit 40 (high phase) of a read
    phy_word = 16'h5555;
    d0 = done_cnt;
    send(READ, 5'd0, 5'd1, 16'h0000, 3'd4);
    repeat (163) @(negedge clk_i);
    chk("pre_reset_mdc", mdc_o, 1);
    chk("pre_reset_oe", mdio_oe_o, 1);
    areset_i = 1'b1;
    #1;
    chk("reset_oe", mdio_oe_o, 0);
    chk("reset_mdc", mdc_o, 0);
    chk("reset_ready", cmd_ready_o, 1);
    chk("reset_busy", busy_o, 0);
    repeat (2) @(negedge clk_i);
    areset_i = 1'b0;
    repeat (300) @(negedge clk_i);
    chk("no_done_after_reset", done_cnt, d0);
    chk("rsp_after_reset", rsp_data_o, 0);
    chk("sel_after_reset", mdio_sel_o, 0);

    // normal read after the aborted one
    phy_word = 16'h0F0F;
    expect_frame(32'h3090_0000, 1'b1, 16'h0F0F, 1'b0, 3'd6);
    send(READ, 5'd1, 5'd4, 16'h0000, 3'd6);
    wait_done(d0 + 1);

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
